vblank_scheduler: RTL and testbench
===================================

Name: vblank_scheduler

Overview:
Frame-synchronous arbiter that shares the vertical-blanking window between up to N game-logic/update requesters (sprite position update, score update, frame-buffer writes). It watches the vblnk output of the VGA timing generator and opens a new arbitration round at each blanking start. Within a round it grants requesters one at a time, using a done handshake, a per-grant timeout and round-robin fairness across frames. It sits between the timing generator and the per-frame update engines, so that no state changes while pixels are being drawn.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT, 20000, maximum clk cycles a single grant may be held (1..65535)
TW, 16, timer width; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  pixel clock (65 MHz)
rst  in  1  synchronous active-high reset
vblnk  in  1  vertical blanking from the timing generator, registered, high for the whole blank interval
req  in  N  level request per requester; sampled only in SCAN
done  in  N  single-cycle completion pulse from the granted requester
grant  out  N  one-hot or zero, registered
frame_tick  out  1  one-cycle pulse at the start of each round
busy  out  1  high in SCAN or GRANT
timeout_err  out  1  one-cycle pulse when a grant is revoked by the timer
overrun  out  1  one-cycle pulse when vblnk falls while a grant is active

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. All outputs are registered.
- Reset values: grant=0, frame_tick=0, busy=0, timeout_err=0, overrun=0, state=IDLE, served=0, start_idx=0, timer=0.
- vblnk_d resets to 1. A blank interval already in progress when reset releases does not start a round.
- Blank-start detection: rise = vblnk & ~vblnk_d.
- States: IDLE, SCAN, GRANT, WAIT_END.
- IDLE: on rise, go to SCAN and set frame_tick=1 for one cycle.
  - At the same edge: served<=0, scan_base<=start_idx, start_idx<=(start_idx+1) mod N.
- SCAN (one cycle):
  - If vblnk=0, go to IDLE.
  - Otherwise pick the first index i, searched in rotating order from scan_base, with req[i] & ~served[i].
  - Found: grant<=onehot(i), served[i]<=1, timer<=0, go to GRANT.
  - None found: go to WAIT_END.
- GRANT (grant held constant), priority high to low:
  - done[g]: grant<=0, go to SCAN.
  - vblnk=0: grant<=0, overrun=1, go to IDLE.
  - timer==TIMEOUT-1: grant<=0, timeout_err=1, go to SCAN.
  - Otherwise timer<=timer+1.
  - done on a non-granted index is ignored.
  - If done and the vblnk fall coincide, done wins: no overrun is raised, and the following SCAN sees vblnk=0 and returns to IDLE.
- WAIT_END: go to IDLE when vblnk=0. No grants are issued.
- Service limit: each requester is served at most once per round, whether it completes or times out.
- Latency, where edge k is the first clock edge at which vblnk is sampled high:
  - frame_tick is visible after edge k.
  - The first grant is visible after edge k+1.
  - After done, the next grant is visible 2 cycles later (one SCAN cycle, no gap).
- Dropped request: if req[i] falls during SCAN, i is not granted. The block does not check that req stays high during GRANT.
- Reset asserted mid-grant: grant goes to 0 at the next edge, and no overrun or timeout_err pulse is produced.

Decomposition:
- Shared constants header (vga_sched_defs): the state encodings IDLE=2'd0, SCAN=2'd1, GRANT=2'd2, WAIT_END=2'd3, and the VESA 1024x768 blank length of 38 lines × 1344 = 51072 cycles, used to check TIMEOUT.
- One sub-module, rr_pick: a combinational rotating-priority encoder.
  - Inputs: req & ~served, base.
  - Outputs: valid, one-hot result.
  - Parameterised by N.

Test Plan:
- N=4; req=4'b1111 held; done pulsed 3 cycles after each grant; blank of 200 cycles -> grants 0001, 0010, 0100, 1000 in order, then WAIT_END and busy=0. The next frame starts at index 1: 0010, 0100, 1000, 0001.
- TIMEOUT=8; req=4'b0001; done never pulsed -> grant 0001 held exactly 8 cycles, timeout_err pulses once, no re-grant in that frame, overrun=0.
- req=4'b0100; done withheld; vblnk falls after 50 cycles -> grant drops at the next edge, overrun=1 for one cycle, state returns to IDLE. The next frame grants requester 2 again.
- done[g] and the vblnk fall in the same cycle -> grant drops, overrun=0, no further grant, busy=0 two cycles later.
- rst released while vblnk=1 -> no frame_tick and no grant until vblnk has gone 0 and then 1. frame_tick is 1 cycle wide and grant appears 1 cycle after it.
- rst pulsed during an active grant -> grant=0 on the next edge, all pulse outputs 0, start_idx=0 (the next frame starts its search at index 0).

Source files
------------

// File: rtl/vblank_scheduler_pkg.sv
// Shared definitions for the vertical-blank scheduler: FSM encodings and the
// VESA 1024x768 blank length that bounds a single grant.
package vblank_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        GRANT    = 2'd2,
        WAIT_END = 2'd3
    } sched_state_e;

    localparam int BLANK_LINES  = 38;
    localparam int LINE_CYCLES  = 1344;
    localparam int BLANK_CYCLES = BLANK_LINES * LINE_CYCLES;

    // A grant longer than a whole blank could never complete inside one round.
    function automatic bit timeout_params_ok(input int timeout, input int tw);
        return (timeout >= 1) && (timeout <= 65535) && (timeout <= BLANK_CYCLES) &&
               (tw >= 1) && (tw < 31) && ((1 << tw) > timeout);
    endfunction

endpackage

// File: rtl/vblank_scheduler_rr_pick.sv
// Combinational rotating-priority encoder: returns the first set candidate
// found when searching upward from base, wrapping at N.
module vblank_scheduler_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] base,
    output logic          valid,
    output logic [N-1:0]  onehot
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] b, input int k);
        int s;
        s = int'(b) + k;
        if (s >= N) begin
            s = s - N;
        end
        return s[IW-1:0];
    endfunction

    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (!valid && cand[wrap_idx(base, k)]) begin
                valid                    = 1'b1;
                onehot[wrap_idx(base, k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vblank_scheduler.sv
// Frame-synchronous arbiter: opens one round per vertical-blank start and
// grants requesters one at a time with done handshake, timeout and rotation.
module vblank_scheduler
    import vblank_scheduler_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 20000,
    parameter int TW      = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vblnk,
    input  logic [N-1:0] req,
    input  logic [N-1:0] done,
    output logic [N-1:0] grant,
    output logic         frame_tick,
    output logic         busy,
    output logic         timeout_err,
    output logic         overrun,
    output logic [1:0]   dbg_state
);

    localparam int IW = $clog2(N);

    if (!timeout_params_ok(TIMEOUT, TW) || (N < 2) || (N > 8)) begin : g_bad_params
        $error("vblank_scheduler: N must be 2..8, TIMEOUT 1..65535 within one blank, 2^TW > TIMEOUT");
    end

    sched_state_e  state_q, state_d;
    logic          vblnk_d_q, vblnk_d_d;
    logic [N-1:0]  served_q, served_d;
    logic [IW-1:0] start_idx_q, start_idx_d;
    logic [IW-1:0] scan_base_q, scan_base_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          frame_tick_q, frame_tick_d;
    logic          busy_q, busy_d;
    logic          timeout_err_q, timeout_err_d;
    logic          overrun_q, overrun_d;

    logic          rise;
    logic [N-1:0]  cand;
    logic          pick_valid;
    logic [N-1:0]  pick_onehot;

    assign rise = vblnk & ~vblnk_d_q;
    assign cand = req & ~served_q;

    vblank_scheduler_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .cand   (cand),
        .base   (scan_base_q),
        .valid  (pick_valid),
        .onehot (pick_onehot)
    );

    // Handshake: grant is held one-hot until the granted requester pulses its
    // done bit for one cycle; done bits of other requesters are ignored, and
    // the scheduler may revoke grant early on timeout or end of blank.
    always_comb begin
        state_d       = state_q;
        vblnk_d_d     = vblnk;
        served_d      = served_q;
        start_idx_d   = start_idx_q;
        scan_base_d   = scan_base_q;
        timer_d       = timer_q;
        grant_d       = grant_q;
        frame_tick_d  = 1'b0;
        timeout_err_d = 1'b0;
        overrun_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d      = SCAN;
                    frame_tick_d = 1'b1;
                    served_d     = '0;
                    scan_base_d  = start_idx_q;
                    start_idx_d  = (start_idx_q == IW'(N - 1)) ? '0 : start_idx_q + IW'(1);
                end
            end
            SCAN: begin
                if (!vblnk) begin
                    state_d = IDLE;
                end else if (pick_valid) begin
                    grant_d  = pick_onehot;
                    served_d = served_q | pick_onehot;
                    timer_d  = '0;
                    state_d  = GRANT;
                end else begin
                    state_d = WAIT_END;
                end
            end
            GRANT: begin
                // A completion in the same cycle as the blank end still counts as done.
                if (|(done & grant_q)) begin
                    grant_d = '0;
                    state_d = SCAN;
                end else if (!vblnk) begin
                    grant_d   = '0;
                    overrun_d = 1'b1;
                    state_d   = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    grant_d       = '0;
                    timeout_err_d = 1'b1;
                    state_d       = SCAN;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_END: begin
                if (!vblnk) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SCAN) || (state_d == GRANT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            vblnk_d_q     <= 1'b1;
            served_q      <= '0;
            start_idx_q   <= '0;
            scan_base_q   <= '0;
            timer_q       <= '0;
            grant_q       <= '0;
            frame_tick_q  <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vblnk_d_q     <= vblnk_d_d;
            served_q      <= served_d;
            start_idx_q   <= start_idx_d;
            scan_base_q   <= scan_base_d;
            timer_q       <= timer_d;
            grant_q       <= grant_d;
            frame_tick_q  <= frame_tick_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign grant       = grant_q;
    assign frame_tick  = frame_tick_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Bench for vblank_scheduler: cycle table for reset/blank-edge corners, plus
// frame sequences whose grant order is checked against an expected queue.
module tb_vblank_scheduler;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic       clk;
    logic       rst;
    logic       vblnk, vblnk2;
    logic [3:0] req, done, req2, done2;
    logic [3:0] grant, grant2;
    logic       frame_tick, busy, timeout_err, overrun;
    logic       frame_tick2, busy2, timeout_err2, overrun2;
    logic [1:0] dbg_state, dbg_state2;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_q[$];
    logic [3:0] prev_grant = 4'b0;

    vblank_scheduler #(.N(4), .TIMEOUT(300), .TW(16)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .req(req), .done(done),
        .grant(grant), .frame_tick(frame_tick), .busy(busy),
        .timeout_err(timeout_err), .overrun(overrun), .dbg_state(dbg_state)
    );

    vblank_scheduler #(.N(4), .TIMEOUT(8), .TW(16)) dut_to (
        .clk(clk), .rst(rst), .vblnk(vblnk2), .req(req2), .done(done2),
        .grant(grant2), .frame_tick(frame_tick2), .busy(busy2),
        .timeout_err(timeout_err2), .overrun(overrun2), .dbg_state(dbg_state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; vblnk = 1'b0; req = 4'b0; done = 4'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    // One blank interval on the main DUT; the requester model answers each
    // grant with done after done_after cycles (0 = never answers).
    task automatic run_frame(input logic [3:0] r, input int blank_len,
                             input int done_after, input int exp_grants);
        int hold, tick_at, ngr, last_done_at;
        req = r; vblnk = 1'b1; done = 4'b0;
        hold = 0; tick_at = -1000; ngr = 0; last_done_at = -1;
        for (int c = 0; c < blank_len; c++) begin
            cycle();
            if (frame_tick) tick_at = c;
            if (grant != 4'b0) begin
                if (hold == 0) begin
                    ngr++;
                    if (ngr == 1) chk("first_grant_latency", c - tick_at, 1);
                    else if (last_done_at >= 0) chk("regrant_latency", c - last_done_at, 2);
                end
                hold++;
                if (done_after > 0 && hold == done_after) begin
                    done = grant;
                    last_done_at = c;
                end else begin
                    done = 4'b0;
                end
            end else begin
                hold = 0;
                done = 4'b0;
            end
        end
        done = 4'b0;
        chk("grants_in_frame", ngr, exp_grants);
    endtask

    // scoreboard: every new grant on the main DUT must match the queue head
    always @(negedge clk) begin
        if (!rst && grant != 4'b0 && prev_grant == 4'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL grant_order: got %b with no grant expected", grant);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (grant !== e) begin
                    failures++;
                    $display("FAIL grant_order: got %b expected %b", grant, e);
                end
            end
        end
        prev_grant = grant;
    end

    typedef struct {
        logic       rst;
        logic       vblnk;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic       tick;
        logic       busy;
        logic       terr;
        logic       ovr;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int held, nterr, nrise, novr;
        logic [3:0] prevg;

        rst = 1'b1; vblnk = 1'b1; req = 4'b0; done = 4'b0;
        vblnk2 = 1'b0; req2 = 4'b0; done2 = 4'b0;

        //            rst   vblnk  req      done     grant    tick  busy  terr  ovr   state
        tbl[0]  = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE};
        tbl[1]  = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE};
        tbl[2]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE};
        tbl[3]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE};
        tbl[4]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE};
        tbl[5]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, S_SCAN};
        tbl[6]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, S_GRANT};
        tbl[7]  = '{1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, S_SCAN};
        tbl[8]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, S_WAIT};
        tbl[9]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, S_WAIT};
        tbl[10] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE};
        tbl[11] = '{1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, S_SCAN};
        tbl[12] = '{1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, S_GRANT};
        tbl[13] = '{1'b0, 1'b1, 4'b0010, 4'b0001, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, S_GRANT};
        tbl[14] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, S_SCAN};
        tbl[15] = '{1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE};
        tbl[16] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE};

        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; vblnk = tbl[i].vblnk; req = tbl[i].req; done = tbl[i].done;
            if (tbl[i].grant != 4'b0 && (i == 0 || tbl[i-1].grant == 4'b0))
                exp_q.push_back(tbl[i].grant);
            cycle();
            chk($sformatf("row%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("row%0d_frame_tick", i), 32'(frame_tick), 32'(tbl[i].tick));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d_timeout_err", i), 32'(timeout_err), 32'(tbl[i].terr));
            chk($sformatf("row%0d_overrun", i), 32'(overrun), 32'(tbl[i].ovr));
            chk($sformatf("row%0d_state", i), 32'(dbg_state), 32'(tbl[i].st));
        end

        // timeout: single requester never answers, TIMEOUT = 8
        req2 = 4'b0001;
        cycle();
        vblnk2 = 1'b1;
        held = 0; nterr = 0; nrise = 0; novr = 0; prevg = 4'b0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (grant2 == 4'b0001) held++;
            if (grant2 != 4'b0 && prevg == 4'b0) nrise++;
            if (timeout_err2) begin
                nterr++;
                chk("timeout_grant_dropped", 32'(grant2), 32'(4'b0000));
                chk("timeout_hold_cycles", held, 8);
            end
            if (overrun2) novr++;
            prevg = grant2;
        end
        chk("timeout_total_hold", held, 8);
        chk("timeout_err_pulses", nterr, 1);
        chk("timeout_no_regrant", nrise, 1);
        chk("timeout_busy_after", 32'(busy2), 32'(1'b0));
        vblnk2 = 1'b0;
        cycle();
        if (overrun2) novr++;
        chk("timeout_no_overrun", novr, 0);
        chk("timeout_state_idle", 32'(dbg_state2), 32'(S_IDLE));

        // round robin across two frames
        do_reset();
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        run_frame(4'b1111, 200, 3, 4);
        chk("rr1_busy_end", 32'(busy), 32'(1'b0));
        chk("rr1_wait_end", 32'(dbg_state), 32'(S_WAIT));
        vblnk = 1'b0;
        cycle();
        chk("rr1_idle", 32'(dbg_state), 32'(S_IDLE));
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        run_frame(4'b1111, 200, 3, 4);
        vblnk = 1'b0;
        cycle();

        // overrun: grant still held when the blank ends
        exp_q.push_back(4'b0100);
        run_frame(4'b0100, 50, 0, 1);
        chk("ovr_grant_before", 32'(grant), 32'(4'b0100));
        vblnk = 1'b0;
        cycle();
        chk("ovr_grant_dropped", 32'(grant), 32'(4'b0000));
        chk("ovr_pulse", 32'(overrun), 32'(1'b1));
        chk("ovr_no_timeout", 32'(timeout_err), 32'(1'b0));
        chk("ovr_state_idle", 32'(dbg_state), 32'(S_IDLE));
        chk("ovr_busy", 32'(busy), 32'(1'b0));
        cycle();
        chk("ovr_pulse_width", 32'(overrun), 32'(1'b0));
        exp_q.push_back(4'b0100);
        run_frame(4'b0100, 20, 3, 1);
        vblnk = 1'b0;
        cycle();

        // reset during an active grant, then reset released inside a blank
        exp_q.push_back(4'b0100);
        req = 4'b0100; vblnk = 1'b1;
        cycle();
        chk("rstg_tick", 32'(frame_tick), 32'(1'b1));
        cycle();
        cycle();
        chk("rstg_granted", 32'(grant), 32'(4'b0100));
        rst = 1'b1;
        cycle();
        chk("rstg_grant", 32'(grant), 32'(4'b0000));
        chk("rstg_overrun", 32'(overrun), 32'(1'b0));
        chk("rstg_timeout", 32'(timeout_err), 32'(1'b0));
        chk("rstg_tick0", 32'(frame_tick), 32'(1'b0));
        chk("rstg_busy", 32'(busy), 32'(1'b0));
        chk("rstg_state", 32'(dbg_state), 32'(S_IDLE));
        rst = 1'b0;
        cycle();
        chk("rstg_no_round_tick", 32'(frame_tick), 32'(1'b0));
        cycle();
        chk("rstg_no_round_grant", 32'(grant), 32'(4'b0000));
        vblnk = 1'b0;
        cycle();
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        run_frame(4'b1111, 40, 3, 4);
        vblnk = 1'b0;
        cycle();
        cycle();

        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
